// File: rtl/exh_pkg.sv
// exh_pkg: sweep state type and sweep-length helper shared by exh_vector_checker and its benches
package exh_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;
  function automatic int sweep_len(input int n_in, input int settle);
    return (1 << n_in) * (settle + 1) + 1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, clr has priority over inc
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/exh_vector_checker.sv
// exh_vector_checker: exhaustive 2^N_IN stimulus sweep with settle hold, DUT-vs-golden compare and saturating error count; FIRST_FAIL_CAPTURE_EN adds first-failure capture
module exh_vector_checker
  import exh_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] dut_y,
  input  logic [N_OUT-1:0] exp_y,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass,
  output logic [N_IN-1:0]  first_vec,
  output logic [N_OUT-1:0] first_y
);
  localparam int CW = $clog2(SETTLE + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic mis, chk, acc;
  assign mis = dut_y !== exp_y;
  assign chk = state == CHECK;
  assign acc = state == IDLE && start;
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk),
    .rst(rst),
    .inc(chk && mis),
    .clr(acc),
    .q(err_cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            vec   <= '0;
            cnt   <= '0;
            pass  <= 1'b0;
            busy  <= 1'b1;
            state <= APPLY;
          end
        APPLY: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 1)) state <= CHECK;
        end
        CHECK:
          if (vec == '1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= err_cnt == '0 && !mis;
            state <= FINISH;
          end else begin
            vec   <= vec + 1'b1;
            cnt   <= '0;
            state <= APPLY;
          end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      first_vec <= '0;
      first_y   <= '0;
    end else if (acc) begin
      first_vec <= '0;
      first_y   <= '0;
    end else if (chk && mis && err_cnt == '0) begin
      first_vec <= vec;
      first_y   <= dut_y;
    end
`else
  assign first_vec = '0;
  assign first_y   = '0;
`endif
endmodule

// File: doc/exh_vector_checker.md
Name: exh_vector_checker

Overview:
Synthesizable exhaustive stimulus/check engine for small combinational DUTs such as N-input gates.
- Steps an N-bit input vector through all 2^N values.
- Waits a programmable settle time after each step.
- Compares the DUT output against a golden-model output and counts mismatches.
- Replaces hand-written per-combination monitor benches; sits between a control master and a DUT/golden-model pair.

Parameters:
N_IN, 2, DUT input width (1..16); vector space 2^N_IN
N_OUT, 1, DUT output width (1..32)
SETTLE, 2, cycles the vector is held before sampling (>=1)
ERR_W, 8, mismatch counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begins a sweep when idle
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at sweep completion
vec  out  N_IN  stimulus to DUT and golden model
dut_y  in  N_OUT  DUT response
exp_y  in  N_OUT  golden-model response
err_cnt  out  ERR_W  mismatches in last/current sweep
pass  out  1  high after done when err_cnt==0; cleared on start
first_vec  out  N_IN  first failing vector (optional feature)
first_y  out  N_OUT  DUT output at first failure (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, vec=0, busy=0, done=0, err_cnt=0, pass=0, settle counter=0, first_vec=0, first_y=0.
- State machine states: IDLE, APPLY, CHECK, FINISH.
- IDLE:
  - start=1 -> vec<=0, err_cnt<=0, pass<=0, settle cnt<=0, busy<=1, go to APPLY.
  - start=0 -> stay in IDLE.
- APPLY: vec is held. Settle counter increments each cycle. When the count reaches SETTLE-1, go to CHECK.
- CHECK (one cycle): dut_y and exp_y are sampled this cycle.
  - On mismatch, err_cnt increments, saturating at 2^ERR_W-1 with no wrap.
  - If vec == 2^N_IN-1, go to FINISH.
  - Otherwise vec<=vec+1, settle cnt<=0, go to APPLY.
- FINISH (one cycle): done<=1, busy<=0, pass<=(err_cnt==0 including the final compare), go to IDLE.
- Timing:
  - done is high for exactly 1 cycle.
  - Cycles from the start cycle to the done-high cycle = 2^N_IN*(SETTLE+1)+1.
  - Each vector is stable for SETTLE+1 cycles.
- start while busy: ignored; a sweep is never restarted mid-run.
- start in the same cycle done is asserted (FINISH): ignored. start is accepted in IDLE only.
- Wrap-around: vec never wraps inside a sweep; the last vector is all-ones. vec holds its final value in IDLE until the next start.
- Reset mid-sweep: immediate return to reset values. No done pulse, pass=0.
- err_cnt and pass hold their values after done until the next accepted start.
- X on dut_y counts as a mismatch. Use !== semantics in simulation; in synthesis, plain inequality.

Optional Feature:
FIRST_FAIL_CAPTURE_EN
- Defined:
  - On the first mismatch of a sweep (err_cnt==0 before the increment), first_vec<=vec and first_y<=dut_y.
  - Later mismatches do not update them.
  - Both are cleared to 0 on accepted start and on reset.
- Undefined: first_vec and first_y are tied to 0 and the capture registers are not generated.

Decomposition:
- Package exh_pkg: state enum type (IDLE/APPLY/CHECK/FINISH) and a localparam function computing the sweep length 2^N_IN*(SETTLE+1)+1 for benches.
- Sub-module sat_counter (parameter W; inc, clr inputs; saturating at all-ones) for err_cnt.
- Settle counter and vector counter stay inline.

Test Plan:
- AND gate, N_IN=2, N_OUT=1, SETTLE=2, exp_y=a&b, dut_y=a&b -> vec sequence 0,1,2,3, each held 3 cycles; done 13 cycles after the start cycle; err_cnt=0; pass=1.
- Same setup with the DUT an OR gate -> mismatches at vec=1,2; err_cnt=2; pass=0; with FIRST_FAIL_CAPTURE_EN, first_vec=1 and first_y=1.
- ERR_W=2, N_IN=3, dut_y=~exp_y -> 8 mismatches; err_cnt saturates at 3; pass=0.
- start pulsed at cycles 5 and 7 of a running sweep, and again in the FINISH cycle -> no restart; exactly one done; vec sequence unchanged.
- rst asserted asynchronously mid-APPLY at vec=2 -> all outputs return to reset values at once; no done pulse; next start sweeps cleanly from vec=0.
- N_IN=1, SETTLE=1 -> vec 0,1, each held 2 cycles; done 5 cycles after start.
